hpdmc_ddrseq: RTL and testbench

DDR data-path sequencer between the HPDMC command scheduler and the DDR I/O block. Tracks every read and write burst, drives the DQ/DQS output-enable (`direction`), and marks when write data is consumed and read data is valid. Enforces same-direction spacing and bus turnaround through `read_safe`/`write_safe`. Serialises DQ input-delay tap adjustments into quiet gaps in bus traffic.

---
 rtl/hpdmc_ddrseq_if.sv | 35 +++
 rtl/hpdmc_ddrseq.sv | 174 +++++++++++++++++
 tb/tb_hpdmc_ddrseq.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hpdmc_ddrseq_if.sv
`default_nettype none
// ============================================================================
//  Module   : hpdmc_ddrseq_if
//  Purpose  : Scheduler-side and I/O-side signals of the HPDMC DDR sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
interface hpdmc_ddrseq_if;
    logic       issue_read;
    logic       issue_write;
    logic       read_safe;
    logic       write_safe;
    logic       direction;
    logic       wdata_next;
    logic       rdata_valid;
    logic [1:0] dly_cmd;
    logic       dly_ack;
    logic [5:0] tap;
    logic       idelay_rst;
    logic       idelay_ce;
    logic       idelay_inc;
    logic       proto_err;

    modport master (
        output issue_read, issue_write, dly_cmd,
        input  read_safe, write_safe, direction, wdata_next, rdata_valid,
               dly_ack, tap, idelay_rst, idelay_ce, idelay_inc, proto_err
    );

    modport slave (
        input  issue_read, issue_write, dly_cmd,
        output read_safe, write_safe, direction, wdata_next, rdata_valid,
               dly_ack, tap, idelay_rst, idelay_ce, idelay_inc, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/hpdmc_ddrseq.sv
`default_nettype none
// ============================================================================
//  Module   : hpdmc_ddrseq
//  Purpose  : DDR data-path sequencer: burst tracking, bus turnaround spacing
//             and IDELAY tap adjustment during quiet bus gaps.
//  Revision : 1.0 - initial release
// ============================================================================
module hpdmc_ddrseq #(
    parameter int READ_LAT = 4,   // must be >= 2
    parameter int BURST    = 2,   // must be >= 2
    parameter int TURN     = 2,
    parameter int SETTLE   = 3,   // must be >= 1
    parameter int TAP_MAX  = 63
) (
    input  wire           sys_clk,
    input  wire           sys_rst_n,
    hpdmc_ddrseq_if.slave bus
);

    localparam int c_CNT_W  = $clog2(READ_LAT + BURST + TURN + 1);
    localparam int c_SCNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam int c_RSR_W  = READ_LAT + BURST - 2;
    localparam int c_WSR_W  = BURST - 1;

    localparam logic [c_CNT_W-1:0]  c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0]  c_SAME_GAP  = c_CNT_W'(BURST - 1);
    localparam logic [c_CNT_W-1:0]  c_R2W_GAP   = c_CNT_W'(READ_LAT + BURST + TURN - 1);
    localparam logic [c_CNT_W-1:0]  c_W2R_GAP   = c_CNT_W'(BURST + TURN);
    localparam logic [c_SCNT_W-1:0] c_SCNT_LOAD = c_SCNT_W'(SETTLE - 1);
    localparam logic [c_SCNT_W-1:0] c_SCNT_ONE  = c_SCNT_W'(1);
    localparam logic [5:0]          c_TAP_MAX   = 6'(TAP_MAX);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_QUIET = 3'd1,
        S_PULSE      = 3'd2,
        S_SETTLE     = 3'd3,
        S_ACK        = 3'd4
    } dstate_t;

    dstate_t              r_dstate, w_dstate_next;
    logic [c_CNT_W-1:0]   r_rcnt, r_wcnt, w_rcnt_next, w_wcnt_next;
    logic [c_SCNT_W-1:0]  r_scnt, w_scnt_next;
    logic [c_RSR_W-1:0]   r_rd_sr;
    logic [c_WSR_W-1:0]   r_wr_sr;
    logic [5:0]           r_tap;
    logic                 r_direction, r_wdata_next, r_rdata_valid, r_proto_err;
    logic                 r_idelay_rst, r_idelay_ce, r_idelay_inc, r_dly_ack;
    logic                 w_rst_next, w_ce_next, w_inc_next, w_ack_next, w_go_pulse;
    logic                 w_read_safe, w_write_safe, w_quiet, w_illegal;
    logic                 w_rd_go, w_wr_go, w_dly_idle;

    assign w_quiet      = (r_rcnt == '0) && (r_wcnt == '0);
    assign w_dly_idle   = (bus.dly_cmd == 2'b00) && (r_dstate == S_IDLE);
    assign w_read_safe  = (r_rcnt == '0) && w_dly_idle;
    assign w_write_safe = (r_wcnt == '0) && w_dly_idle;
    assign w_illegal    = (bus.issue_read  && !w_read_safe)  ||
                          (bus.issue_write && !w_write_safe) ||
                          (bus.issue_read  && bus.issue_write);
    assign w_rd_go      = bus.issue_read  && !w_illegal;
    assign w_wr_go      = bus.issue_write && !w_illegal;

    // Loads take the larger of the running count and the new spacing.
    always_comb begin
        w_rcnt_next = (r_rcnt != '0) ? r_rcnt - c_CNT_ONE : r_rcnt;
        w_wcnt_next = (r_wcnt != '0) ? r_wcnt - c_CNT_ONE : r_wcnt;
        if (w_rd_go) begin
            w_rcnt_next = (r_rcnt > c_SAME_GAP) ? r_rcnt : c_SAME_GAP;
            w_wcnt_next = (r_wcnt > c_R2W_GAP)  ? r_wcnt : c_R2W_GAP;
        end else if (w_wr_go) begin
            w_wcnt_next = (r_wcnt > c_SAME_GAP) ? r_wcnt : c_SAME_GAP;
            w_rcnt_next = (r_rcnt > c_W2R_GAP)  ? r_rcnt : c_W2R_GAP;
        end
    end

    always_comb begin
        w_dstate_next = r_dstate;
        w_scnt_next   = r_scnt;
        w_go_pulse    = 1'b0;
        w_rst_next    = 1'b0;
        w_ce_next     = 1'b0;
        w_inc_next    = 1'b0;
        w_ack_next    = 1'b0;
        case (r_dstate)
            S_IDLE: begin
                if (bus.dly_cmd != 2'b00) begin
                    w_dstate_next = S_WAIT_QUIET;
                    w_go_pulse    = w_quiet;
                end
            end
            S_WAIT_QUIET: w_go_pulse = w_quiet;
            S_PULSE: begin
                w_dstate_next = S_SETTLE;
                w_scnt_next   = c_SCNT_LOAD;
            end
            S_SETTLE: begin
                if (r_scnt == '0) begin
                    w_dstate_next = S_ACK;
                    w_ack_next    = 1'b1;
                end else begin
                    w_scnt_next = r_scnt - c_SCNT_ONE;
                end
            end
            S_ACK:   w_dstate_next = S_IDLE;
            default: w_dstate_next = S_IDLE;
        endcase
        // Saturated inc/dec still walks through SETTLE/ACK, just without a CE pulse.
        if (w_go_pulse) begin
            w_dstate_next = S_PULSE;
            case (bus.dly_cmd)
                2'b11: w_rst_next = 1'b1;
                2'b01: if (r_tap != c_TAP_MAX) begin
                    w_ce_next  = 1'b1;
                    w_inc_next = 1'b1;
                end
                2'b10: if (r_tap != '0) w_ce_next = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_dstate      <= S_IDLE;
            r_rcnt        <= '0;
            r_wcnt        <= '0;
            r_scnt        <= '0;
            r_rd_sr       <= '0;
            r_wr_sr       <= '0;
            r_tap         <= '0;
            r_direction   <= 1'b0;
            r_wdata_next  <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_proto_err   <= 1'b0;
            r_idelay_rst  <= 1'b0;
            r_idelay_ce   <= 1'b0;
            r_idelay_inc  <= 1'b0;
            r_dly_ack     <= 1'b0;
        end else begin
            r_dstate      <= w_dstate_next;
            r_rcnt        <= w_rcnt_next;
            r_wcnt        <= w_wcnt_next;
            r_scnt        <= w_scnt_next;
            r_rd_sr       <= (r_rd_sr << 1) | c_RSR_W'(w_rd_go);
            r_wr_sr       <= (r_wr_sr << 1) | c_WSR_W'(w_wr_go);
            r_direction   <= w_wr_go || (|r_wr_sr);
            r_wdata_next  <= w_wr_go || (|r_wr_sr);
            r_rdata_valid <= |r_rd_sr[c_RSR_W-1:READ_LAT-2];
            r_proto_err   <= r_proto_err || w_illegal;
            r_idelay_rst  <= w_rst_next;
            r_idelay_ce   <= w_ce_next;
            r_idelay_inc  <= w_inc_next;
            r_dly_ack     <= w_ack_next;
            if (r_idelay_rst)
                r_tap <= '0;
            else if (r_idelay_ce)
                r_tap <= r_idelay_inc ? r_tap + 6'd1 : r_tap - 6'd1;
        end
    end

    assign bus.read_safe   = w_read_safe;
    assign bus.write_safe  = w_write_safe;
    assign bus.direction   = r_direction;
    assign bus.wdata_next  = r_wdata_next;
    assign bus.rdata_valid = r_rdata_valid;
    assign bus.dly_ack     = r_dly_ack;
    assign bus.tap         = r_tap;
    assign bus.idelay_rst  = r_idelay_rst;
    assign bus.idelay_ce   = r_idelay_ce;
    assign bus.idelay_inc  = r_idelay_inc;
    assign bus.proto_err   = r_proto_err;

endmodule
`default_nettype wire

// File: tb/tb_hpdmc_ddrseq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hpdmc_ddrseq
//  Purpose  : Randomized bench for hpdmc_ddrseq against a timing-rule model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_hpdmc_ddrseq;
    localparam int READ_LAT = 4;
    localparam int BURST    = 2;
    localparam int TURN     = 2;
    localparam int SETTLE   = 3;
    localparam int TAP_MAX  = 63;

    logic sys_clk   = 1'b0;
    logic sys_rst_n = 1'b0;
    always #5 sys_clk = ~sys_clk;

    hpdmc_ddrseq_if bus();

    hpdmc_ddrseq #(
        .READ_LAT (READ_LAT),
        .BURST    (BURST),
        .TURN     (TURN),
        .SETTLE   (SETTLE),
        .TAP_MAX  (TAP_MAX)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cur_cyc = 0;

    // Model state: last legal issue times, in-flight bursts, delay operation.
    int         lr, lw;
    int         rq[$];
    int         wq[$];
    bit         m_err;
    int         m_tap, m_tap_after;
    int         m_seen, m_pulse, m_ack;
    bit         m_ce, m_inc, m_rst;
    bit         cmd_active;
    logic [1:0] cur_cmd;
    logic [1:0] cmd_q[$];

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d: got %0h, want %0h", tag, cur_cyc, act, exp);
        end
    endtask

    function automatic bit rd_ok(input int c);
        return (c >= lr + BURST) && (c >= lw + BURST + TURN + 1);
    endfunction

    function automatic bit wr_ok(input int c);
        return (c >= lw + BURST) && (c >= lr + READ_LAT + BURST + TURN);
    endfunction

    function automatic bit dly_busy(input int c);
        return (c > m_seen) && (c <= m_ack);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic reset_model();
        lr = -1000; lw = -1000;
        rq.delete(); wq.delete();
        m_err = 0; m_tap = 0; m_tap_after = 0;
        m_seen = -10; m_pulse = -10; m_ack = -10;
        m_ce = 0; m_inc = 0; m_rst = 0;
        cmd_active = 0; cur_cmd = 2'b00;
    endtask

    task automatic do_reset(input int hold);
        @(negedge sys_clk);
        sys_rst_n       = 1'b0;
        bus.issue_read  = 1'b0;
        bus.issue_write = 1'b0;
        bus.dly_cmd     = 2'b00;
        repeat (hold) @(posedge sys_clk);
        @(negedge sys_clk);
        cur_cyc = -1;
        chk("rst_direction",  bus.direction,   0);
        chk("rst_wdata_next", bus.wdata_next,  0);
        chk("rst_rdata_valid",bus.rdata_valid, 0);
        chk("rst_dly_ack",    bus.dly_ack,     0);
        chk("rst_idelay_ce",  bus.idelay_ce,   0);
        chk("rst_idelay_inc", bus.idelay_inc,  0);
        chk("rst_idelay_rst", bus.idelay_rst,  0);
        chk("rst_tap",        bus.tap,         0);
        chk("rst_proto_err",  bus.proto_err,   0);
        chk("rst_read_safe",  bus.read_safe,   1);
        chk("rst_write_safe", bus.write_safe,  1);
        sys_rst_n = 1'b1;
        reset_model();
    endtask

    task automatic run_cycle(input int c, input bit traffic, input bit allow_bad);
        bit ir, iw, rs, ws, exp_rv, exp_dir;
        int r, q;
        @(negedge sys_clk);
        cur_cyc = c;
        // Requester: hold the command until ack, release it the cycle after.
        if (cmd_active && c == m_ack + 1) begin
            cmd_active = 0;
            cur_cmd    = 2'b00;
        end else if (!cmd_active && c > m_ack + 1) begin
            if (cmd_q.size() > 0) begin
                cur_cmd    = cmd_q.pop_front();
                cmd_active = 1;
            end else if (traffic && $urandom_range(0, 29) == 0) begin
                r          = $urandom_range(0, 99);
                cur_cmd    = (r < 45) ? 2'b01 : (r < 80) ? 2'b10 : 2'b11;
                cmd_active = 1;
            end
        end
        rs = rd_ok(c) && (cur_cmd == 2'b00) && !dly_busy(c);
        ws = wr_ok(c) && (cur_cmd == 2'b00) && !dly_busy(c);
        ir = 0; iw = 0;
        if (traffic) begin
            r = $urandom_range(0, 99);
            if (allow_bad && r < 12) begin
                ir = 1'($urandom_range(0, 1));
                iw = 1'($urandom_range(0, 1));
            end else if (r < 45) ir = rs;
            else if (r < 80) iw = ws;
        end
        bus.issue_read  = ir;
        bus.issue_write = iw;
        bus.dly_cmd     = cur_cmd;
        #1;
        if (c == m_pulse + 1) m_tap = m_tap_after;
        exp_rv = 0;
        foreach (rq[i]) if (c >= rq[i] + READ_LAT && c <= rq[i] + READ_LAT + BURST - 1) exp_rv = 1;
        exp_dir = 0;
        foreach (wq[i]) if (c >= wq[i] + 1 && c <= wq[i] + BURST) exp_dir = 1;

        chk("read_safe",   bus.read_safe,   rs);
        chk("write_safe",  bus.write_safe,  ws);
        chk("rdata_valid", bus.rdata_valid, exp_rv);
        chk("direction",   bus.direction,   exp_dir);
        chk("wdata_next",  bus.wdata_next,  exp_dir);
        chk("idelay_ce",   bus.idelay_ce,   (c == m_pulse) && m_ce);
        chk("idelay_inc",  bus.idelay_inc,  (c == m_pulse) && m_inc);
        chk("idelay_rst",  bus.idelay_rst,  (c == m_pulse) && m_rst);
        chk("dly_ack",     bus.dly_ack,     c == m_ack);
        chk("tap",         bus.tap,         m_tap);
        chk("proto_err",   bus.proto_err,   m_err);

        if ((ir && !rs) || (iw && !ws) || (ir && iw)) begin
            m_err = 1;
        end else begin
            if (ir) begin lr = c; rq.push_back(c); end
            if (iw) begin lw = c; wq.push_back(c); end
        end
        while (rq.size() > 0 && rq[0] + READ_LAT + BURST <= c) void'(rq.pop_front());
        while (wq.size() > 0 && wq[0] + BURST <= c) void'(wq.pop_front());

        // New delay command: pulse on the cycle after the bus first goes quiet.
        if (cur_cmd != 2'b00 && !dly_busy(c)) begin
            q = max2(c, max2(max2(lr + BURST, lw + BURST + TURN + 1),
                             max2(lw + BURST, lr + READ_LAT + BURST + TURN)));
            m_seen  = c;
            m_pulse = q + 1;
            m_ack   = m_pulse + SETTLE + 1;
            m_rst   = (cur_cmd == 2'b11);
            m_inc   = (cur_cmd == 2'b01) && (m_tap < TAP_MAX);
            m_ce    = m_inc || ((cur_cmd == 2'b10) && (m_tap > 0));
            m_tap_after = m_rst ? 0 : m_ce ? (m_inc ? m_tap + 1 : m_tap - 1) : m_tap;
        end
    endtask

    initial begin
        int c;
        bus.issue_read  = 1'b0;
        bus.issue_write = 1'b0;
        bus.dly_cmd     = 2'b00;
        reset_model();

        // Tap walk: saturate at TAP_MAX, walk down past 0, then reset the tap.
        do_reset(2);
        for (int i = 0; i < TAP_MAX + 1; i++) cmd_q.push_back(2'b01);
        for (int i = 0; i < TAP_MAX + 2; i++) cmd_q.push_back(2'b10);
        cmd_q.push_back(2'b01);
        cmd_q.push_back(2'b01);
        cmd_q.push_back(2'b11);
        c = 0;
        while ((cmd_q.size() > 0 || cmd_active) && c < 5000) begin
            run_cycle(c, 1'b0, 1'b0);
            c++;
        end
        for (int i = 0; i < 4; i++) run_cycle(c + i, 1'b0, 1'b0);
        chk("dly_queue_drained", cmd_q.size() + int'(cmd_active), 0);

        // Random traffic phases; odd phases inject illegal issues.
        for (int p = 0; p < 6; p++) begin
            do_reset($urandom_range(1, 3));
            for (int i = 0; i < 1500 + int'($urandom_range(0, 37)); i++)
                run_cycle(i, 1'b1, p[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
